// File: rtl/psum_reducer.sv
// Serial final-reduction stage: sums NUM_PSUM aligned partial sums into one WIDTH-bit product plus an overflow flag.
// Optional macro PSUM_REDUCER_PAIR_EN folds two partial sums per accumulate cycle.
module psum_reducer #(
  parameter int RADIX    = 108,
  parameter int WIDTH    = RADIX * 2,
  parameter int NUM_PSUM = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_PSUM*WIDTH-1:0] psum_bus,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_ovf,
  output logic                      busy
);

  localparam int ACCW  = $clog2(NUM_PSUM);
  localparam int ACCTW = WIDTH + ACCW;
  localparam int IDXW  = (ACCW < 1) ? 1 : ACCW;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_bank [NUM_PSUM];
  logic [ACCTW-1:0]   r_acc;
  logic [IDXW-1:0]    r_idx;
  logic [WIDTH-1:0]   r_outData;
  logic               r_outOvf;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH:0]     w_addend;
  logic [ACCTW-1:0]   w_accNext;
  logic [IDXW-1:0]    w_idxStep;
  logic [IDXW-1:0]    w_idxLast;

`ifdef PSUM_REDUCER_PAIR_EN
  // idx is always even here, so OR-ing in bit 0 selects the odd partner
  assign w_addend  = {1'b0, r_bank[r_idx]} + {1'b0, r_bank[r_idx | IDXW'(1)]};
  assign w_idxStep = IDXW'(2);
  assign w_idxLast = IDXW'(NUM_PSUM - 2);
`else
  assign w_addend  = {1'b0, r_bank[r_idx]};
  assign w_idxStep = IDXW'(1);
  assign w_idxLast = IDXW'(NUM_PSUM - 1);
`endif

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_last    = (r_state == ACCUM) && (r_idx == w_idxLast);
  assign w_accNext = r_acc + ACCTW'(w_addend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_nextState = ACCUM;
      ACCUM:   if (w_last) w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // in_ready is gated by rst so nothing is offered while reset is held
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE:    in_ready  = !rst;
      ACCUM:   busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // The bank is fully overwritten on every accept, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < NUM_PSUM; k++) begin
        r_bank[k] <= psum_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_idx     <= '0;
      r_outData <= '0;
      r_outOvf  <= 1'b0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (r_state == ACCUM) begin
      r_acc <= w_accNext;
      r_idx <= r_idx + w_idxStep;
      if (w_last) begin
        r_outData <= w_accNext[WIDTH-1:0];
        r_outOvf  <= |w_accNext[ACCTW-1:WIDTH];
      end
    end
  end

  assign out_data = r_outData;
  assign out_ovf  = r_outOvf;

endmodule

// File: tb/tb_psum_reducer.sv
// Self-checking bench for psum_reducer: a transaction-level model checked every cycle, plus hand-computed results.
module tb_psum_reducer;

  localparam int WIDTH    = 216;
  localparam int NUM_PSUM = 8;
  localparam int BUSW     = NUM_PSUM * WIDTH;
`ifdef PSUM_REDUCER_PAIR_EN
  localparam int LAT = NUM_PSUM / 2;
  localparam int LAT_LIT = 4;
`else
  localparam int LAT = NUM_PSUM;
  localparam int LAT_LIT = 8;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [BUSW-1:0]  psum_bus;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             busy;

  int checks = 0;
  int errors = 0;

  psum_reducer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .psum_bus  (psum_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH+7:0] modelSum(input logic [BUSW-1:0] bus);
    logic [WIDTH+7:0] s;
    s = '0;
    for (int k = 0; k < NUM_PSUM; k++) s = s + {8'b0, bus[k*WIDTH +: WIDTH]};
    return s;
  endfunction

  function automatic logic [BUSW-1:0] fillBus(input logic [WIDTH-1:0] v);
    logic [BUSW-1:0] b;
    for (int k = 0; k < NUM_PSUM; k++) b[k*WIDTH +: WIDTH] = v;
    return b;
  endfunction

  // Transaction-level model: 0 = waiting for a bundle, 1 = summing, 2 = holding a result
  int               mMode;
  int               mCount;
  logic [WIDTH+7:0] mSum;
  logic [WIDTH-1:0] expData;
  logic             expOvf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mMode   <= 0;
      mCount  <= 0;
      mSum    <= '0;
      expData <= '0;
      expOvf  <= 1'b0;
    end else begin
      case (mMode)
        0: if (in_valid) begin
          mSum   <= modelSum(psum_bus);
          mCount <= LAT;
          mMode  <= 1;
        end
        1: begin
          mCount <= mCount - 1;
          if (mCount == 1) begin
            expData <= mSum[WIDTH-1:0];
            expOvf  <= |mSum[WIDTH+7:WIDTH];
            mMode   <= 2;
          end
        end
        default: if (out_ready) mMode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    checkOutput("cmp_in_ready", WIDTH'(in_ready), WIDTH'((mMode == 0) && !rst));
    checkOutput("cmp_out_valid", WIDTH'(out_valid), WIDTH'(mMode == 2));
    checkOutput("cmp_busy", WIDTH'(busy), WIDTH'(mMode != 0));
    checkOutput("cmp_out_data", out_data, expData);
    checkOutput("cmp_out_ovf", WIDTH'(out_ovf), WIDTH'(expOvf));
  end

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic waitValid(output int lat);
    bit found;
    found = 1'b0;
    lat = 0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      #1;
      if (out_valid) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_out_valid timed out actual=0 expected=1");
    end
  endtask

  task automatic applyStimulus(input logic [BUSW-1:0] bus, input bit readyEarly, input int hold,
                               output logic [WIDTH-1:0] data, output logic ovf, output int lat);
    in_valid  = 1'b1;
    psum_bus  = bus;
    out_ready = readyEarly;
    checkOutput("accept_in_ready", WIDTH'(in_ready), WIDTH'(1));
    @(posedge clk);
    nextCycle();
    in_valid = 1'b0;
    psum_bus = ~bus;
    waitValid(lat);
    lat = lat + 1;
    data = out_data;
    ovf  = out_ovf;
    repeat (hold) nextCycle();
    out_ready = 1'b1;
    @(posedge clk);
    nextCycle();
    out_ready = 1'b0;
    checkOutput("valid_dropped", WIDTH'(out_valid), WIDTH'(0));
    checkOutput("ready_after_done", WIDTH'(in_ready), WIDTH'(1));
  endtask

  logic [BUSW-1:0]  bus;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] d;
  logic             o;
  int               lat;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; psum_bus = '0;
    repeat (3) nextCycle();
    checkOutput("rst_in_ready", WIDTH'(in_ready), WIDTH'(0));
    checkOutput("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
    checkOutput("rst_busy", WIDTH'(busy), WIDTH'(0));
    checkOutput("rst_out_data", out_data, WIDTH'(0));
    rst = 1'b0;
    nextCycle();
    checkOutput("post_rst_in_ready", WIDTH'(in_ready), WIDTH'(1));

    // waitValid counts from the cycle after accept; the +1 inside applyStimulus restores acceptance-relative latency
    applyStimulus(fillBus(WIDTH'(1)), 1'b1, 0, d, o, lat);
    checkOutput("ones_data", d, WIDTH'(8));
    checkOutput("ones_ovf", WIDTH'(o), WIDTH'(0));
    checkOutput("ones_latency", WIDTH'(lat - 1), WIDTH'(LAT_LIT));

    for (int k = 0; k < NUM_PSUM; k++) bus[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
    applyStimulus(bus, 1'b0, 2, d, o, lat);
    checkOutput("ramp_data", d, WIDTH'(36));
    checkOutput("ramp_ovf", WIDTH'(o), WIDTH'(0));

    v = '0; v[215] = 1'b1;
    applyStimulus(fillBus(v), 1'b0, 0, d, o, lat);
    checkOutput("top_bit_data", d, WIDTH'(0));
    checkOutput("top_bit_ovf", WIDTH'(o), WIDTH'(1));

    bus = '0;
    bus[0 +: WIDTH] = '1;
    bus[WIDTH +: WIDTH] = WIDTH'(1);
    applyStimulus(bus, 1'b0, 0, d, o, lat);
    checkOutput("carry_data", d, WIDTH'(0));
    checkOutput("carry_ovf", WIDTH'(o), WIDTH'(1));

    // Backpressure with in_valid held high and a changing bus
    in_valid = 1'b1;
    psum_bus = fillBus(WIDTH'(2));
    @(posedge clk);
    nextCycle();
    psum_bus = {54{$urandom()}};
    waitValid(lat);
    checkOutput("bp_first_data", out_data, WIDTH'(16));
    for (int c = 0; c < 5; c++) begin
      nextCycle();
      psum_bus = {54{$urandom()}};
      checkOutput("bp_stable_data", out_data, WIDTH'(16));
      checkOutput("bp_in_ready_low", WIDTH'(in_ready), WIDTH'(0));
    end
    psum_bus  = fillBus(WIDTH'(3));
    out_ready = 1'b1;
    @(posedge clk);
    nextCycle();
    out_ready = 1'b0;
    checkOutput("bp_in_ready_high", WIDTH'(in_ready), WIDTH'(1));
    @(posedge clk);
    nextCycle();
    in_valid = 1'b0;
    waitValid(lat);
    checkOutput("bp_second_data", out_data, WIDTH'(24));
    out_ready = 1'b1;
    @(posedge clk);
    nextCycle();
    out_ready = 1'b0;

    // Reset during the third accumulate cycle
    in_valid = 1'b1;
    psum_bus = fillBus(WIDTH'(5));
    @(posedge clk);
    nextCycle();
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    nextCycle();
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", WIDTH'(out_valid), WIDTH'(0));
    checkOutput("abort_out_data", out_data, WIDTH'(0));
    checkOutput("abort_busy", WIDTH'(busy), WIDTH'(0));
    nextCycle();
    rst = 1'b0;
    nextCycle();
    checkOutput("abort_in_ready", WIDTH'(in_ready), WIDTH'(1));
    applyStimulus(fillBus(WIDTH'(1)), 1'b0, 1, d, o, lat);
    checkOutput("after_abort_data", d, WIDTH'(8));
    checkOutput("after_abort_ovf", WIDTH'(o), WIDTH'(0));

    repeat (2) nextCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
